// File: rtl/ps2_pkg.sv
// Shared scan-code constants, frame state type and hex-key lookup
// for the PS/2 keypad front end.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // {hit, nibble} for scan-code-set-2 make codes of 0-9 and A-F
  function automatic logic [4:0] hex_decode(input logic [7:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      8'h45: r = 5'h10;
      8'h16: r = 5'h11;
      8'h1E: r = 5'h12;
      8'h26: r = 5'h13;
      8'h25: r = 5'h14;
      8'h2E: r = 5'h15;
      8'h36: r = 5'h16;
      8'h3D: r = 5'h17;
      8'h3E: r = 5'h18;
      8'h46: r = 5'h19;
      8'h1C: r = 5'h1A;
      8'h32: r = 5'h1B;
      8'h21: r = 5'h1C;
      8'h23: r = 5'h1D;
      8'h24: r = 5'h1E;
      8'h2B: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchronizer, falling-edge detect and 11-bit frame
// deframer with parity/stop checking and a mid-frame timeout.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   bit_in;
  logic                   fall;

  frame_state_t state;
  frame_state_t state_nxt;

  logic [2:0]    bcnt;
  logic [7:0]    sreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          frame_ok;

  // Idle bus is high, so the chains reset to 1 to avoid a fake edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_cur = clk_sync[SYNC_STAGES-1];
  assign bit_in  = dat_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_cur;

  assign timeout = (state != IDLE) && !fall &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!bit_in) state_nxt = DATA;
        DATA:    if (bcnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= 3'd0;
      sreg <= 8'h00;
      par  <= 1'b0;
      tcnt <= '0;
    end else begin
      if (state == IDLE || fall || timeout) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
      if (fall) begin
        case (state)
          IDLE: bcnt <= 3'd0;
          DATA: begin
            sreg <= {bit_in, sreg[7:1]};
            bcnt <= bcnt + 3'd1;
          end
          PARITY:  par <= bit_in;
          default: ;
        endcase
      end
    end
  end

  // Stop bit must be 1 and data+parity must carry odd ones
  assign frame_ok = bit_in & (^{sreg, par});

  always_comb begin
    byte_o       = sreg;
    byte_valid_o = 1'b0;
    err_o        = timeout;
    if (state == STOP && fall) begin
      byte_valid_o = frame_ok;
      err_o        = ~frame_ok;
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard front end: deframes scan codes and emits key strobes.
// Build with PS2_HEX_DECODE_EN to translate 0-9/A-F keys to nibbles.
module ps2_keypad #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ps2_data_o,
  output logic       ps2_valid_o,
  output logic       ps2_done_o,
  output logic       ps2_reset_o,
  output logic       frame_err_o
);

  import ps2_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic       break_pending;
  logic       ext_pending;
  logic       brk_nxt;
  logic       ext_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       done_nxt;
  logic       esc_nxt;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .err_o        (rx_err)
  );

`ifdef PS2_HEX_DECODE_EN
  logic [4:0] hex;
  assign hex = hex_decode(rx_byte);
`endif

  // Releases and extended keys are swallowed together with their prefix
  always_comb begin
    brk_nxt   = break_pending;
    ext_nxt   = ext_pending;
    data_nxt  = ps2_data_o;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    esc_nxt   = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_nxt = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_nxt = 1'b1;
      end else if (break_pending || ext_pending) begin
        brk_nxt = 1'b0;
        ext_nxt = 1'b0;
      end else if (rx_byte == SC_ENTER) begin
        done_nxt = 1'b1;
      end else if (rx_byte == SC_ESC) begin
        esc_nxt = 1'b1;
      end else begin
`ifdef PS2_HEX_DECODE_EN
        if (hex[4]) begin
          valid_nxt = 1'b1;
          data_nxt  = {4'h0, hex[3:0]};
        end
`else
        valid_nxt = 1'b1;
        data_nxt  = rx_byte;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      ps2_data_o    <= 8'h00;
      ps2_valid_o   <= 1'b0;
      ps2_done_o    <= 1'b0;
      ps2_reset_o   <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      break_pending <= brk_nxt;
      ext_pending   <= ext_nxt;
      ps2_data_o    <= data_nxt;
      ps2_valid_o   <= valid_nxt;
      ps2_done_o    <= done_nxt;
      ps2_reset_o   <= esc_nxt;
      frame_err_o   <= rx_err;
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed PS/2 frame bench with an event-queue model of the decoder.
// Honours PS2_HEX_DECODE_EN when the RTL is built with it.
module tb_ps2_keypad;

  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int K_VALID = 0;
  localparam int K_DONE  = 1;
  localparam int K_ESC   = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       ps2_done;
  logic       ps2_reset;
  logic       frame_err;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_fall = 0;
  ev_t  q[$];
  logic m_brk = 1'b0;
  logic m_ext = 1'b0;
  logic [7:0] m_last = 8'h00;
  bit   in_reset = 1'b1;
  logic [7:0] cur_byte;
  bit   cur_good;

  logic [7:0] hex_codes [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

`ifdef PS2_HEX_DECODE_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  ps2_keypad #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .ps2_data_o  (ps2_data),
    .ps2_valid_o (ps2_valid),
    .ps2_done_o  (ps2_done),
    .ps2_reset_o (ps2_reset),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d,
                      input int lo, input int hi);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.lo   = lo;
    e.hi   = hi;
    q.push_back(e);
  endtask

  // Decoder rules applied to one good byte arriving at cycle 'at'
  task automatic model_byte(input logic [7:0] b, input int at);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_brk || m_ext) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'h5A) push(K_DONE, 8'h00, at, at);
    else if (b == 8'h76) push(K_ESC, 8'h00, at, at);
    else if (!HEX) push(K_VALID, b, at, at);
    else begin
      for (int i = 0; i < 16; i++)
        if (hex_codes[i] == b) push(K_VALID, 8'(i), at, at);
    end
  endtask

  task automatic send_bit(input logic b, input bit last);
    @(negedge clk);
    ps2_dat = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    if (last) begin
      if (cur_good) model_byte(cur_byte, last_fall + SYNC + 1);
      else push(K_ERR, 8'h00, last_fall + SYNC + 1, last_fall + SYNC + 1);
    end
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input logic stop);
    cur_byte = b;
    cur_good = stop && !bad_par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(stop, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_reset = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(ps2_valid), 0);
    check("rst_done", 32'(ps2_done), 0);
    check("rst_esc", 32'(ps2_reset), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_data", 32'(ps2_data), 0);
    check("rst_queue", q.size(), 0);
    rst = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_last = 8'h00;
    @(negedge clk);
    in_reset = 1'b0;
  endtask

  always @(negedge clk) begin
    int  s;
    int  k;
    ev_t e;
    if (!in_reset) begin
      s = int'(ps2_valid) + int'(ps2_done) + int'(ps2_reset) + int'(frame_err);
      if (s > 0) begin
        check("one_strobe", s, 1);
        k = ps2_valid ? K_VALID : ps2_done ? K_DONE :
            ps2_reset ? K_ESC : K_ERR;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)",
                   k, cyc);
        end else begin
          e = q.pop_front();
          check("strobe_kind", k, e.kind);
          check("strobe_time", 32'(cyc >= e.lo && cyc <= e.hi), 1);
          if (e.kind == K_VALID) m_last = e.data;
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_strobe: got none expected kind %0d by cycle %0d",
                 q[0].kind, q[0].hi);
        void'(q.pop_front());
      end
      check("data_out", 32'(ps2_data), 32'(m_last));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("init_valid", 32'(ps2_valid), 0);
    check("init_done", 32'(ps2_done), 0);
    check("init_esc", 32'(ps2_reset), 0);
    check("init_err", 32'(frame_err), 0);
    check("init_data", 32'(ps2_data), 0);
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1);
    check("lit_1c", 32'(ps2_data), HEX ? 32'h0A : 32'h1C);

    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("lit_hold", 32'(ps2_data), HEX ? 32'h0A : 32'h1C);

    send_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'h76, 1'b0, 1'b1);

    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("lit_err_hold", 32'(ps2_data), HEX ? 32'h0A : 32'h1C);

    send_frame(8'h1E, 1'b0, 1'b1);
    send_frame(8'h1E, 1'b0, 1'b1);
    check("lit_1e", 32'(ps2_data), HEX ? 32'h02 : 32'h1E);
    send_frame(8'h29, 1'b0, 1'b1);

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    push(K_ERR, 8'h00, last_fall + TMO, last_fall + TMO + SYNC + 3);
    repeat (TMO + 20) @(negedge clk);
    send_frame(8'h16, 1'b0, 1'b1);
    check("lit_16", 32'(ps2_data), HEX ? 32'h01 : 32'h16);

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[1], 1'b0);
    do_reset();
    repeat (5) @(negedge clk);
    send_frame(8'h45, 1'b0, 1'b1);
    check("lit_45", 32'(ps2_data), HEX ? 32'h00 : 32'h45);

    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- Upstream input stage of the rsa block.
- Receives raw PS/2 keyboard clock/data pins and deframes the 11-bit serial frames.
- Decodes make/break scan codes and drives the byte stream and control strobes the rsa block consumes in its key-entry state: ps2_data_i, ps2_valid_i, ps2_done, ps2_reset.

Parameters:
- TIMEOUT_CYCLES, 5000, clk cycles with no PS/2 falling edge mid-frame before the frame is aborted.
- SYNC_STAGES, 2, flip-flop stages on ps2_clk_i and ps2_dat_i (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- ps2_clk_i  input  1  raw PS/2 clock pin, asynchronous
- ps2_dat_i  input  1  raw PS/2 data pin, asynchronous
- ps2_data_o  output  8  decoded key byte; feeds rsa ps2_data_i
- ps2_valid_o  output  1  one-cycle strobe, ps2_data_o valid; feeds rsa ps2_valid_i
- ps2_done_o  output  1  one-cycle strobe on Enter make; feeds rsa ps2_done
- ps2_reset_o  output  1  one-cycle strobe on Esc make; feeds rsa ps2_reset
- frame_err_o  output  1  one-cycle strobe on parity, stop or timeout error

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high on rst.
- Reset: all outputs 0. FSM goes to IDLE, bit counter 0, timeout counter 0. break_pending and ext_pending cleared. Sync chains load 1 (idle bus).
- Synchronizer and edge detect: both pins pass through SYNC_STAGES flops. A falling edge (fall) is synced clock previous=1, current=0. Data is sampled on the cycle fall is detected.
- Frame FSM:
  - IDLE: on fall, if data=0 go to DATA with counter=0. If data=1 (glitch), stay in IDLE with no error.
  - DATA: on each fall, shift data into shift register LSB first and increment counter. After the 8th bit go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check stop=1 and odd parity (the 8 data bits plus parity hold an odd number of ones). Pass: present the byte to the decoder and go to IDLE. Fail: pulse frame_err_o, drop the byte, go to IDLE.
- Timeout: counter clears on every fall and increments each cycle while not in IDLE. When it reaches TIMEOUT_CYCLES-1: pulse frame_err_o, go to IDLE, discard partial data. Decoder flags are unchanged.
- Decoder (byte presented, same cycle):
  - F0: set break_pending, no output.
  - E0: set ext_pending, no output.
  - Any other byte with break_pending or ext_pending set: clear both, no output. Extended keys and all key releases are suppressed.
  - 5A: pulse ps2_done_o.
  - 76: pulse ps2_reset_o.
  - Otherwise: ps2_data_o=byte and pulse ps2_valid_o.
- Latency: strobes assert in the clk cycle after the cycle the stop-bit fall is detected. They last exactly 1 cycle.
- ps2_data_o holds its last value between strobes.
- At most one of ps2_valid_o, ps2_done_o, ps2_reset_o is high in any cycle.
- frame_err_o never coincides with the other strobes.
- Typematic repeats: each repeated make code produces its own strobe; no suppression.
- No backpressure: the downstream consumer must sample every valid cycle. Minimum PS/2 frame spacing guarantees strobes are at least 11 fall events apart.
- rst mid-frame: the partial frame is lost. The next start bit after reset is decoded normally.

Optional Feature:
- Macro PS2_HEX_DECODE_EN.
- When defined, make codes for keys 0-9 and A-F are translated to nibble values 0x00-0x0F on ps2_data_o:
  - 45,16,1E,26,25,2E,36,3D,3E,46 map to 0-9.
  - 1C,32,21,23,24,2B map to A-F.
  - All other non-control make codes are dropped silently.
- When undefined, the raw scan code passes through unchanged.
- Enter, Esc and break/extended handling are identical in both builds.

Decomposition:
- Package ps2_pkg holds:
  - scan constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ENTER=8'h5A, SC_ESC=8'h76;
  - frame state enum {IDLE, DATA, PARITY, STOP};
  - hex-decode function returning {hit, nibble}.
- Sub-module ps2_frame_rx contains the synchronizer, edge detect, frame FSM and timeout.
  - Outputs: byte_o, byte_valid_o, err_o.
- ps2_keypad instantiates ps2_frame_rx and contains the decoder.

Test Plan:
- Frame 0x1C: start 0, data 00111000 LSB-first, parity 0, stop 1 → single ps2_valid_o pulse with ps2_data_o=8'h1C; with PS2_HEX_DECODE_EN, 8'h0A.
- Sequence 1C, F0, 1C → exactly one valid pulse; the release produces nothing. Then E0, 75 → no output.
- Frame 0x5A → ps2_done_o pulse only. Frame 0x76 → ps2_reset_o pulse only. ps2_valid_o stays 0 throughout.
- Frame 0x1C with parity bit 1 → frame_err_o pulse, no valid. Frame with stop 0 → frame_err_o pulse.
- Stop toggling after 4 data bits for TIMEOUT_CYCLES clk → frame_err_o pulse, FSM in IDLE. A following good 0x16 frame → valid with 8'h16 (hex build: 8'h01).
- Assert rst for 1 cycle after 6 data bits → all outputs 0. Next full 0x45 frame → valid with 8'h45 (hex build: 8'h00).
